// File: rtl/rs_pkg.sv
// Shared definitions for the reservation station, ROB and dispatch stages.
package rs_pkg;

  localparam int unsigned RS_DEPTH       = 16;
  localparam int unsigned RS_TAG_W       = 5;
  localparam int unsigned RS_VAL_W       = 32;
  localparam int unsigned RS_NUM_CDB     = 2;
  localparam int unsigned RS_FULL_MARGIN = 3;

  // Instruction payload field width (inst / npc / imme)
  localparam int unsigned INST_W = 32;

  // A producer tag of zero means the operand is already available
  localparam int unsigned NO_DEP = 0;

  // Payload carried unchanged from dispatch to the ALU
  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [INST_W-1:0] npc;
    logic [INST_W-1:0] imme;
  } rs_payload_t;

endpackage

// File: rtl/rs_oldest_pick.sv
// Combinational oldest-first arbiter: grants the ready slot with the largest age.
module rs_oldest_pick #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AGE_W = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0]       ready,
  input  logic [DEPTH*AGE_W-1:0] ages,
  output logic [DEPTH-1:0]       grant,
  output logic                   valid
);

  localparam int unsigned IDX_W = $clog2(DEPTH);

  logic [AGE_W-1:0] best_age;
  logic [IDX_W-1:0] best_idx;

  // Linear max-search over ready slots; ages are unique so no tie-break is needed
  always_comb begin
    grant    = '0;
    valid    = 1'b0;
    best_age = '0;
    best_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ready[i] && (!valid || (ages[i*AGE_W +: AGE_W] > best_age))) begin
        valid    = 1'b1;
        best_age = ages[i*AGE_W +: AGE_W];
        best_idx = IDX_W'(i);
      end
    end
    if (valid) grant[best_idx] = 1'b1;
  end

endmodule

// File: rtl/rs_station_multi.sv
// Reservation station: tag-tracked operands, multi-channel CDB wakeup, oldest-first issue.
module rs_station_multi
  import rs_pkg::*;
#(
  parameter int unsigned DEPTH       = RS_DEPTH,
  parameter int unsigned TAG_W       = RS_TAG_W,
  parameter int unsigned VAL_W       = RS_VAL_W,
  parameter int unsigned NUM_CDB     = RS_NUM_CDB,
  parameter int unsigned FULL_MARGIN = RS_FULL_MARGIN
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic                       rdy_in,
  input  logic                       clear,
  input  logic                       disp_valid,
  input  logic [INST_W-1:0]          disp_inst,
  input  logic [INST_W-1:0]          disp_npc,
  input  logic [INST_W-1:0]          disp_imme,
  input  logic [TAG_W-1:0]           disp_tag,
  input  logic [VAL_W-1:0]           disp_rs1_val,
  input  logic [VAL_W-1:0]           disp_rs2_val,
  input  logic [TAG_W-1:0]           disp_rs1_rely,
  input  logic [TAG_W-1:0]           disp_rs2_rely,
  input  logic [NUM_CDB-1:0]         cdb_valid,
  input  logic [NUM_CDB*TAG_W-1:0]   cdb_tag,
  input  logic [NUM_CDB*VAL_W-1:0]   cdb_val,
  input  logic                       iss_ready,
  output logic                       iss_valid,
  output logic [INST_W-1:0]          iss_inst,
  output logic [INST_W-1:0]          iss_npc,
  output logic [INST_W-1:0]          iss_imme,
  output logic [VAL_W-1:0]           iss_rs1_val,
  output logic [VAL_W-1:0]           iss_rs2_val,
  output logic [TAG_W-1:0]           iss_tag,
  output logic [$clog2(DEPTH):0]     rs_count,
  output logic                       rs_full
);

  localparam int unsigned AGE_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = AGE_W + 1;

  // Entry array
  logic [DEPTH-1:0] busy;
  logic [AGE_W-1:0] age      [DEPTH];
  rs_payload_t      pl       [DEPTH];
  logic [TAG_W-1:0] tag      [DEPTH];
  logic [VAL_W-1:0] rs1_val  [DEPTH];
  logic [TAG_W-1:0] rs1_rely [DEPTH];
  logic [VAL_W-1:0] rs2_val  [DEPTH];
  logic [TAG_W-1:0] rs2_rely [DEPTH];

  // Post-wakeup operand state for every entry
  logic [VAL_W-1:0] wk1_val  [DEPTH];
  logic [TAG_W-1:0] wk1_rely [DEPTH];
  logic [VAL_W-1:0] wk2_val  [DEPTH];
  logic [TAG_W-1:0] wk2_rely [DEPTH];

  // Dispatch operands after same-cycle bypass
  logic [VAL_W-1:0] d1_val;
  logic [TAG_W-1:0] d1_rely;
  logic [VAL_W-1:0] d2_val;
  logic [TAG_W-1:0] d2_rely;

  logic [DEPTH-1:0]       ready;
  logic [DEPTH*AGE_W-1:0] ages_flat;
  logic [DEPTH-1:0]       grant;
  logic                   pick_valid;
  logic [AGE_W-1:0]       pick_idx;
  logic [AGE_W-1:0]       free_idx;
  logic [AGE_W-1:0]       iss_age;
  logic                   disp_ok;
  logic                   load;
  logic                   fire;

  rs_payload_t disp_pl;
  assign disp_pl = '{inst: disp_inst, npc: disp_npc, imme: disp_imme};

  // Snoop all broadcast channels for one operand; lowest channel index wins
  function automatic logic [TAG_W+VAL_W-1:0] snoop(
    input logic [TAG_W-1:0]         rely,
    input logic [VAL_W-1:0]         val,
    input logic [NUM_CDB-1:0]       cv,
    input logic [NUM_CDB*TAG_W-1:0] ct,
    input logic [NUM_CDB*VAL_W-1:0] cd
  );
    logic [TAG_W+VAL_W-1:0] res;
    res = {rely, val};
    for (int c = NUM_CDB - 1; c >= 0; c--) begin
      if (cv[c] && (rely != TAG_W'(NO_DEP)) && (ct[c*TAG_W +: TAG_W] == rely))
        res = {TAG_W'(NO_DEP), cd[c*VAL_W +: VAL_W]};
    end
    return res;
  endfunction

  // Wakeup compare for stored entries and bypass for the incoming dispatch
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      {wk1_rely[i], wk1_val[i]} = snoop(rs1_rely[i], rs1_val[i], cdb_valid, cdb_tag, cdb_val);
      {wk2_rely[i], wk2_val[i]} = snoop(rs2_rely[i], rs2_val[i], cdb_valid, cdb_tag, cdb_val);
    end
    {d1_rely, d1_val} = snoop(disp_rs1_rely, disp_rs1_val, cdb_valid, cdb_tag, cdb_val);
    {d2_rely, d2_val} = snoop(disp_rs2_rely, disp_rs2_val, cdb_valid, cdb_tag, cdb_val);
  end

  // Readiness from registered state only; a wakeup becomes issuable next cycle
  always_comb begin
    ready     = '0;
    ages_flat = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ready[i] = busy[i] && (rs1_rely[i] == TAG_W'(NO_DEP)) && (rs2_rely[i] == TAG_W'(NO_DEP));
      ages_flat[i*AGE_W +: AGE_W] = age[i];
    end
  end

  rs_oldest_pick #(
    .DEPTH (DEPTH),
    .AGE_W (AGE_W)
  ) u_pick (
    .ready (ready),
    .ages  (ages_flat),
    .grant (grant),
    .valid (pick_valid)
  );

  // Free-slot encoder, grant index, and handshake decisions
  always_comb begin
    free_idx = '0;
    pick_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!busy[i]) free_idx = AGE_W'(i);
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (grant[i]) pick_idx = AGE_W'(i);
    end
    iss_age = age[pick_idx];
    disp_ok = disp_valid && (rs_count < CNT_W'(DEPTH));
    load    = !iss_valid || iss_ready;
    fire    = load && pick_valid;
  end

  // Entry array update: dispatch, wakeup, age ranking and count.
  // Entries older than an issued one move down a rank, so ages stay a dense
  // 0..count-1 ranking and never wrap however long an entry waits.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      busy     <= '0;
      rs_count <= '0;
      for (int i = 0; i < DEPTH; i++) age[i] <= '0;
    end else if (rdy_in) begin
      if (clear) begin
        busy     <= '0;
        rs_count <= '0;
        for (int i = 0; i < DEPTH; i++) age[i] <= '0;
      end else begin
        for (int i = 0; i < DEPTH; i++) begin
          rs1_val[i]  <= wk1_val[i];
          rs1_rely[i] <= wk1_rely[i];
          rs2_val[i]  <= wk2_val[i];
          rs2_rely[i] <= wk2_rely[i];
          if (busy[i])
            age[i] <= age[i] + AGE_W'(disp_ok) - AGE_W'(fire && (age[i] > iss_age));
        end
        if (fire) busy[pick_idx] <= 1'b0;
        if (disp_ok) begin
          busy[free_idx]     <= 1'b1;
          age[free_idx]      <= '0;
          pl[free_idx]       <= disp_pl;
          tag[free_idx]      <= disp_tag;
          rs1_val[free_idx]  <= d1_val;
          rs1_rely[free_idx] <= d1_rely;
          rs2_val[free_idx]  <= d2_val;
          rs2_rely[free_idx] <= d2_rely;
        end
        rs_count <= rs_count + CNT_W'(disp_ok) - CNT_W'(fire);
      end
    end
  end

  // Issue output register: reloads when empty or consumed, holds under back-pressure
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      iss_valid   <= 1'b0;
      iss_inst    <= '0;
      iss_npc     <= '0;
      iss_imme    <= '0;
      iss_rs1_val <= '0;
      iss_rs2_val <= '0;
      iss_tag     <= '0;
    end else if (rdy_in) begin
      if (clear) begin
        iss_valid   <= 1'b0;
        iss_inst    <= '0;
        iss_npc     <= '0;
        iss_imme    <= '0;
        iss_rs1_val <= '0;
        iss_rs2_val <= '0;
        iss_tag     <= '0;
      end else if (load) begin
        if (pick_valid) begin
          iss_valid   <= 1'b1;
          iss_inst    <= pl[pick_idx].inst;
          iss_npc     <= pl[pick_idx].npc;
          iss_imme    <= pl[pick_idx].imme;
          iss_rs1_val <= rs1_val[pick_idx];
          iss_rs2_val <= rs2_val[pick_idx];
          iss_tag     <= tag[pick_idx];
        end else begin
          iss_valid <= 1'b0;
        end
      end
    end
  end

  assign rs_full = (rs_count >= CNT_W'(DEPTH - FULL_MARGIN));

endmodule

// File: tb/tb_rs_station_multi.sv
// Self-checking bench for rs_station_multi: directed table, corner sequences, random vs queue model.
module tb_rs_station_multi;

  localparam int unsigned DEPTH       = 16;
  localparam int unsigned TAG_W       = 5;
  localparam int unsigned VAL_W       = 32;
  localparam int unsigned NUM_CDB     = 2;
  localparam int unsigned FULL_MARGIN = 3;
  localparam int unsigned CNT_W       = 5;

  logic                     clk_in;
  logic                     rst_in, rdy_in, clear, disp_valid, iss_ready;
  logic [31:0]              disp_inst, disp_npc, disp_imme;
  logic [TAG_W-1:0]         disp_tag, disp_rs1_rely, disp_rs2_rely;
  logic [VAL_W-1:0]         disp_rs1_val, disp_rs2_val;
  logic [NUM_CDB-1:0]       cdb_valid;
  logic [NUM_CDB*TAG_W-1:0] cdb_tag;
  logic [NUM_CDB*VAL_W-1:0] cdb_val;
  logic                     iss_valid;
  logic [31:0]              iss_inst, iss_npc, iss_imme;
  logic [VAL_W-1:0]         iss_rs1_val, iss_rs2_val;
  logic [TAG_W-1:0]         iss_tag;
  logic [CNT_W-1:0]         rs_count;
  logic                     rs_full;

  rs_station_multi #(
    .DEPTH(DEPTH), .TAG_W(TAG_W), .VAL_W(VAL_W), .NUM_CDB(NUM_CDB), .FULL_MARGIN(FULL_MARGIN)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear),
    .disp_valid(disp_valid), .disp_inst(disp_inst), .disp_npc(disp_npc), .disp_imme(disp_imme),
    .disp_tag(disp_tag), .disp_rs1_val(disp_rs1_val), .disp_rs2_val(disp_rs2_val),
    .disp_rs1_rely(disp_rs1_rely), .disp_rs2_rely(disp_rs2_rely),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_val(cdb_val),
    .iss_ready(iss_ready), .iss_valid(iss_valid), .iss_inst(iss_inst), .iss_npc(iss_npc),
    .iss_imme(iss_imme), .iss_rs1_val(iss_rs1_val), .iss_rs2_val(iss_rs2_val),
    .iss_tag(iss_tag), .rs_count(rs_count), .rs_full(rs_full)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // Reference model: waiting instructions kept in arrival order
  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [31:0]      inst, npc, imme;
    logic [VAL_W-1:0] v1;
    logic [TAG_W-1:0] r1;
    logic [VAL_W-1:0] v2;
    logic [TAG_W-1:0] r2;
  } m_ent_t;

  m_ent_t mq[$];
  m_ent_t mo;
  logic   mv;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h", name, act, req);
  endtask

  // Operand capture from the broadcast bus as the rules describe it
  task automatic wake(inout logic [TAG_W-1:0] r, inout logic [VAL_W-1:0] v);
    if (r != '0) begin
      for (int c = 0; c < NUM_CDB; c++) begin
        if (cdb_valid[c] && cdb_tag[c*TAG_W +: TAG_W] == r) begin
          v = cdb_val[c*VAL_W +: VAL_W];
          r = '0;
          break;
        end
      end
    end
  endtask

  task automatic model_edge();
    int     pick;
    int     n0;
    logic   ld;
    m_ent_t e;
    if (rst_in || (rdy_in && clear)) begin
      mq.delete();
      mv = 1'b0;
      mo = '0;
    end else if (rdy_in) begin
      n0   = mq.size();
      pick = -1;
      foreach (mq[i]) if (pick < 0 && mq[i].r1 == '0 && mq[i].r2 == '0) pick = i;
      ld = !mv || iss_ready;
      foreach (mq[i]) begin
        e = mq[i];
        wake(e.r1, e.v1);
        wake(e.r2, e.v2);
        mq[i] = e;
      end
      if (ld) begin
        if (pick >= 0) begin
          mo = mq[pick];
          mv = 1'b1;
          mq.delete(pick);
        end else begin
          mv = 1'b0;
        end
      end
      if (disp_valid && n0 < DEPTH) begin
        e.tag = disp_tag; e.inst = disp_inst; e.npc = disp_npc; e.imme = disp_imme;
        e.v1 = disp_rs1_val; e.r1 = disp_rs1_rely;
        e.v2 = disp_rs2_val; e.r2 = disp_rs2_rely;
        wake(e.r1, e.v1);
        wake(e.r2, e.v2);
        mq.push_back(e);
      end
    end
  endtask

  task automatic check_model();
    chk("m_iss_valid", 64'(iss_valid), 64'(mv));
    if (mv) begin
      chk("m_iss_tag",  64'(iss_tag),     64'(mo.tag));
      chk("m_iss_inst", 64'(iss_inst),    64'(mo.inst));
      chk("m_iss_npc",  64'(iss_npc),     64'(mo.npc));
      chk("m_iss_imme", 64'(iss_imme),    64'(mo.imme));
      chk("m_iss_rs1",  64'(iss_rs1_val), 64'(mo.v1));
      chk("m_iss_rs2",  64'(iss_rs2_val), 64'(mo.v2));
    end
    chk("m_rs_count", 64'(rs_count), 64'(mq.size()));
    chk("m_rs_full",  64'(rs_full),  64'(mq.size() >= int'(DEPTH - FULL_MARGIN)));
  endtask

  // One clock: model follows the sampled inputs, outputs compared 1 time unit later
  task automatic step();
    @(posedge clk_in);
    model_edge();
    #1;
    check_model();
  endtask

  task automatic idle();
    disp_valid = 1'b0;
    cdb_valid  = '0;
  endtask

  task automatic set_disp(input logic [TAG_W-1:0] t, input logic [TAG_W-1:0] r1,
                          input logic [VAL_W-1:0] v1, input logic [TAG_W-1:0] r2,
                          input logic [VAL_W-1:0] v2);
    disp_valid    = 1'b1;
    disp_tag      = t;
    disp_inst     = 32'h1000 + 32'(t);
    disp_npc      = 32'h2000 + 32'(t);
    disp_imme     = 32'h3000 + 32'(t);
    disp_rs1_rely = r1;
    disp_rs1_val  = v1;
    disp_rs2_rely = r2;
    disp_rs2_val  = v2;
  endtask

  task automatic set_cdb(input int ch, input logic [TAG_W-1:0] t, input logic [VAL_W-1:0] v);
    cdb_valid[ch]              = 1'b1;
    cdb_tag[ch*TAG_W +: TAG_W] = t;
    cdb_val[ch*VAL_W +: VAL_W] = v;
  endtask

  // Directed vector: one cycle of stimulus plus the outputs required after the edge
  typedef struct packed {
    logic             dv;
    logic [TAG_W-1:0] tag;
    logic [31:0]      v1;
    logic [TAG_W-1:0] r1;
    logic [31:0]      v2;
    logic [TAG_W-1:0] r2;
    logic [1:0]       cv;
    logic [TAG_W-1:0] ct0;
    logic [31:0]      cd0;
    logic [TAG_W-1:0] ct1;
    logic [31:0]      cd1;
    logic             ev;
    logic [TAG_W-1:0] etag;
    logic [31:0]      e1;
    logic [31:0]      e2;
    logic [CNT_W-1:0] ecnt;
  } vec_t;

  function automatic vec_t mk(input logic dv, input logic [4:0] tg, input logic [4:0] r1,
                              input logic [31:0] v1, input logic [4:0] r2, input logic [31:0] v2,
                              input logic [1:0] cv, input logic [4:0] ct0, input logic [31:0] cd0,
                              input logic [4:0] ct1, input logic [31:0] cd1, input logic ev,
                              input logic [4:0] etag, input logic [31:0] e1, input logic [31:0] e2,
                              input logic [4:0] ecnt);
    vec_t x;
    x.dv = dv; x.tag = tg; x.r1 = r1; x.v1 = v1; x.r2 = r2; x.v2 = v2;
    x.cv = cv; x.ct0 = ct0; x.cd0 = cd0; x.ct1 = ct1; x.cd1 = cd1;
    x.ev = ev; x.etag = etag; x.e1 = e1; x.e2 = e2; x.ecnt = ecnt;
    return x;
  endfunction

  vec_t tbl [13];

  initial begin
    // Three ready ops issue in order; dependent op overtaken; dispatch bypass with lowest-channel priority
    tbl[0]  = mk(1, 1, 0, 32'h101, 0, 32'h201, 2'b00, 0, 0, 0, 0,            0, 0, 0, 0, 1);
    tbl[1]  = mk(1, 2, 0, 32'h102, 0, 32'h202, 2'b00, 0, 0, 0, 0,            1, 1, 32'h101, 32'h201, 1);
    tbl[2]  = mk(1, 3, 0, 32'h103, 0, 32'h203, 2'b00, 0, 0, 0, 0,            1, 2, 32'h102, 32'h202, 1);
    tbl[3]  = mk(0, 0, 0, 0, 0, 0,             2'b00, 0, 0, 0, 0,            1, 3, 32'h103, 32'h203, 0);
    tbl[4]  = mk(0, 0, 0, 0, 0, 0,             2'b00, 0, 0, 0, 0,            0, 0, 0, 0, 0);
    tbl[5]  = mk(1, 4, 7, 32'h0, 0, 32'h204,   2'b00, 0, 0, 0, 0,            0, 0, 0, 0, 1);
    tbl[6]  = mk(1, 5, 0, 32'h105, 0, 32'h205, 2'b00, 0, 0, 0, 0,            0, 0, 0, 0, 2);
    tbl[7]  = mk(0, 0, 0, 0, 0, 0,             2'b11, 3, 32'h1111, 7, 32'hDEAD, 1, 5, 32'h105, 32'h205, 1);
    tbl[8]  = mk(0, 0, 0, 0, 0, 0,             2'b00, 0, 0, 0, 0,            1, 4, 32'hDEAD, 32'h204, 0);
    tbl[9]  = mk(0, 0, 0, 0, 0, 0,             2'b00, 0, 0, 0, 0,            0, 0, 0, 0, 0);
    tbl[10] = mk(1, 6, 0, 32'h106, 9, 32'h0,   2'b11, 9, 32'h55, 9, 32'h77,  0, 0, 0, 0, 1);
    tbl[11] = mk(0, 0, 0, 0, 0, 0,             2'b00, 0, 0, 0, 0,            1, 6, 32'h106, 32'h55, 0);
    tbl[12] = mk(0, 0, 0, 0, 0, 0,             2'b00, 0, 0, 0, 0,            0, 0, 0, 0, 0);

    rst_in = 1'b1; rdy_in = 1'b1; clear = 1'b0; iss_ready = 1'b1;
    disp_valid = 1'b0; disp_tag = '0; disp_inst = '0; disp_npc = '0; disp_imme = '0;
    disp_rs1_rely = '0; disp_rs2_rely = '0; disp_rs1_val = '0; disp_rs2_val = '0;
    cdb_valid = '0; cdb_tag = '0; cdb_val = '0;
    step();
    step();
    chk("rst_valid", 64'(iss_valid), 64'(0));
    chk("rst_inst",  64'(iss_inst),  64'(0));
    chk("rst_rs1",   64'(iss_rs1_val), 64'(0));
    chk("rst_tag",   64'(iss_tag),   64'(0));
    chk("rst_count", 64'(rs_count),  64'(0));
    chk("rst_full",  64'(rs_full),   64'(0));
    rst_in = 1'b0;

    // Table-driven directed vectors
    for (int r = 0; r < 13; r++) begin
      idle();
      if (tbl[r].dv) set_disp(tbl[r].tag, tbl[r].r1, tbl[r].v1, tbl[r].r2, tbl[r].v2);
      if (tbl[r].cv[0]) set_cdb(0, tbl[r].ct0, tbl[r].cd0);
      if (tbl[r].cv[1]) set_cdb(1, tbl[r].ct1, tbl[r].cd1);
      iss_ready = 1'b1;
      step();
      chk($sformatf("row%0d_valid", r), 64'(iss_valid), 64'(tbl[r].ev));
      if (tbl[r].ev) begin
        chk($sformatf("row%0d_tag", r), 64'(iss_tag),     64'(tbl[r].etag));
        chk($sformatf("row%0d_rs1", r), 64'(iss_rs1_val), 64'(tbl[r].e1));
        chk($sformatf("row%0d_rs2", r), 64'(iss_rs2_val), 64'(tbl[r].e2));
      end
      chk($sformatf("row%0d_count", r), 64'(rs_count), 64'(tbl[r].ecnt));
    end
    idle();

    // Fill with dependent ops, full threshold, dropped overflow dispatch, oldest-first drain
    for (int t = 1; t <= 16; t++) begin
      set_disp(TAG_W'(t), 5'd10, 32'h0, 5'd0, 32'h200 + 32'(t));
      step();
      if (t == 12) chk("fill_full12", 64'(rs_full), 64'(0));
      if (t == 13) chk("fill_full13", 64'(rs_full), 64'(1));
    end
    chk("fill_count16", 64'(rs_count), 64'(16));
    set_disp(5'd20, 5'd0, 32'h120, 5'd0, 32'h220);
    step();
    chk("drop_count", 64'(rs_count), 64'(16));
    chk("drop_valid", 64'(iss_valid), 64'(0));
    idle();
    set_cdb(0, 5'd10, 32'hABC);
    step();
    idle();
    for (int k = 1; k <= 16; k++) begin
      step();
      chk($sformatf("drain%0d_tag", k), 64'(iss_tag), 64'(k));
      chk($sformatf("drain%0d_rs1", k), 64'(iss_rs1_val), 64'(32'hABC));
    end
    step();
    chk("drain_end_valid", 64'(iss_valid), 64'(0));
    chk("drain_end_count", 64'(rs_count), 64'(0));

    // Back-pressure: output held stable, then next-oldest follows on release
    iss_ready = 1'b0;
    set_disp(5'd21, 5'd0, 32'h121, 5'd0, 32'h221); step();
    set_disp(5'd22, 5'd0, 32'h122, 5'd0, 32'h222); step();
    set_disp(5'd23, 5'd0, 32'h123, 5'd0, 32'h223); step();
    idle();
    for (int k = 0; k < 3; k++) begin
      step();
      chk("stall_valid", 64'(iss_valid), 64'(1));
      chk("stall_tag",   64'(iss_tag),   64'(21));
      chk("stall_inst",  64'(iss_inst),  64'(32'h1015));
      chk("stall_count", 64'(rs_count),  64'(2));
    end
    iss_ready = 1'b1;
    step(); chk("release_tag1", 64'(iss_tag), 64'(22));
    step(); chk("release_tag2", 64'(iss_tag), 64'(23));
    step(); chk("release_idle", 64'(iss_valid), 64'(0));

    // Flush with five waiting entries, a pending issue and a competing dispatch
    iss_ready = 1'b0;
    set_disp(5'd24, 5'd0, 32'h124, 5'd0, 32'h224); step();
    for (int t = 25; t <= 29; t++) begin
      set_disp(TAG_W'(t), 5'd11, 32'h0, 5'd0, 32'h200 + 32'(t));
      step();
    end
    chk("preclr_count", 64'(rs_count), 64'(5));
    chk("preclr_tag",   64'(iss_tag),  64'(24));
    clear = 1'b1; iss_ready = 1'b1;
    set_disp(5'd30, 5'd0, 32'h130, 5'd0, 32'h230);
    set_cdb(0, 5'd11, 32'h77);
    step();
    clear = 1'b0;
    idle();
    chk("clr_valid", 64'(iss_valid), 64'(0));
    chk("clr_count", 64'(rs_count),  64'(0));
    chk("clr_tag",   64'(iss_tag),   64'(0));
    step();
    chk("clr_after_valid", 64'(iss_valid), 64'(0));
    chk("clr_after_count", 64'(rs_count),  64'(0));

    // Freeze: nothing moves, broadcasts are not captured
    iss_ready = 1'b0;
    set_disp(5'd1, 5'd0, 32'h101, 5'd0, 32'h201); step();
    set_disp(5'd2, 5'd12, 32'h0, 5'd0, 32'h202); step();
    rdy_in = 1'b0; iss_ready = 1'b1;
    set_disp(5'd3, 5'd0, 32'h103, 5'd0, 32'h203);
    set_cdb(0, 5'd12, 32'h999);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("frz_valid", 64'(iss_valid), 64'(1));
      chk("frz_tag",   64'(iss_tag),   64'(1));
      chk("frz_count", 64'(rs_count),  64'(1));
    end
    rdy_in = 1'b1;
    idle();
    step();
    chk("unfrz_valid", 64'(iss_valid), 64'(0));
    chk("unfrz_count", 64'(rs_count),  64'(1));
    set_cdb(0, 5'd12, 32'h999); step();
    idle(); step();
    chk("unfrz_tag", 64'(iss_tag),     64'(2));
    chk("unfrz_rs1", 64'(iss_rs1_val), 64'(32'h999));
    step();

    // Randomized traffic against the queue model
    for (int cyc = 0; cyc < 3000; cyc++) begin
      rdy_in     = ($urandom_range(0, 9) != 0);
      clear      = ($urandom_range(0, 59) == 0);
      iss_ready  = ($urandom_range(0, 3) != 0);
      idle();
      if ($urandom_range(0, 2) != 0 && mq.size() < DEPTH)
        set_disp(TAG_W'($urandom_range(1, 31)),
                 ($urandom_range(0, 1) != 0) ? 5'd0 : TAG_W'($urandom_range(1, 6)), $urandom(),
                 ($urandom_range(0, 1) != 0) ? 5'd0 : TAG_W'($urandom_range(1, 6)), $urandom());
      for (int c = 0; c < NUM_CDB; c++)
        if ($urandom_range(0, 2) == 0) set_cdb(c, TAG_W'($urandom_range(1, 6)), $urandom());
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
